// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker: FSM state
// encoding, default frame width and the fixed framing bit values.
package serial_parity_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

endpackage : serial_parity_pkg

// File: rtl/parity_acc.sv
// One-bit running-parity register: synchronous clear, enable-gated XOR-in,
// asynchronous active-high reset. Clear wins over enable.
module parity_acc
  import serial_parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  logic acc_d;
  logic acc_q;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule : parity_acc

// File: rtl/serial_parity_checker.sv
// Strobed serial frame receiver: start bit, DATA_W data bits LSB first,
// parity bit, stop bit. Reports the word with parity and framing errors.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0);

  state_e              state_d,      state_q;
  logic [CNT_W-1:0]    cnt_d,        cnt_q;
  logic [DATA_W-1:0]   shift_d,      shift_q;
  logic                perr_hold_d,  perr_hold_q;
  logic [DATA_W-1:0]   data_out_d,   data_out_q;
  logic                valid_d,      valid_q;
  logic                parity_err_d, parity_err_q;
  logic                frame_err_d,  frame_err_q;

  logic acc_clr;
  logic acc_en;
  logic acc;

  parity_acc u_parity_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (din),
    .acc (acc)
  );

  // Every transition is gated by bit_en, so a stalled line freezes the
  // whole receiver, including the accumulator enable.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    perr_hold_d  = perr_hold_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (din == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end
        end

        ST_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shift_d[i] = din;
            end
          end
          acc_en = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_PARITY;
          end
        end

        ST_PARITY: begin
          // Data bits plus parity bit XOR to ODD_BIT on a clean frame.
          perr_hold_d = acc ^ din ^ ODD_BIT;
          state_d     = ST_STOP;
        end

        ST_STOP: begin
          valid_d      = 1'b1;
          data_out_d   = shift_q;
          parity_err_d = perr_hold_q;
          frame_err_d  = (din != STOP_BIT);
          state_d      = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: the data shift register is reset along with the control flops;
  // it is small, and a reset value keeps data_out deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      perr_hold_q  <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      perr_hold_q  <= perr_hold_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule : serial_parity_checker

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, range 1..16.
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 = even parity, 1 = odd parity.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port bit_en  input  1  strobe; din is sampled only on edges where bit_en=1.
REQ-006 SHALL have port din  input  1  serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_W  last received data word, LSB first on the line.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 SHALL have port parity_err  output  1  parity mismatch; meaningful only while valid=1.
REQ-010 SHALL have port frame_err  output  1  stop bit sampled as 0; meaningful only while valid=1.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame SHALL be: start bit 0, then DATA_W data bits LSB first, then 1 parity bit, then stop bit 1.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY and STOP; transitions happen only on edges where bit_en=1.
REQ-014 Transition IDLE->DATA SHALL occur when din=0; din=1 in IDLE keeps the FSM in IDLE.
REQ-015 In DATA, each strobe SHALL shift din into bit index cnt and XOR it into the parity accumulator.
REQ-016 The FSM SHALL move DATA->PARITY after DATA_W strobes; cnt SHALL be $clog2(DATA_W+1) bits wide and clear on entry to DATA.
REQ-017 In PARITY, the accumulator SHALL be XORed with din and ODD_PARITY, and the result held as the error bit; then the FSM SHALL move to STOP.
REQ-018 In STOP, the strobe SHALL complete the frame and the FSM SHALL return to IDLE.
REQ-019 On completion, valid SHALL be 1 in the cycle following the stop-bit sampling edge, for exactly one cycle.
REQ-020 On completion, data_out, parity_err and frame_err SHALL update on the same edge as valid.
REQ-021 data_out SHALL hold its value until the next completed frame; parity_err and frame_err SHALL be 0 whenever valid=0.
REQ-022 parity_err and frame_err SHALL be able to assert together.
REQ-023 A frame with frame_err=1 SHALL still deliver data_out and valid.
REQ-024 With bit_en=0, all state, cnt and the accumulator SHALL hold; valid SHALL not re-pulse.
REQ-025 A start bit SHALL be accepted on the first strobe after STOP (back-to-back frames), with no idle strobe required.
REQ-026 Latency from stop-bit strobe to valid SHALL be exactly 1 clock, independent of bit_en spacing.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE and cnt, accumulator, data_out, valid, parity_err, frame_err and busy SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no valid pulse; reception restarts from IDLE after release.
REQ-029 The first edge after rst deasserts SHALL be treated as a normal sampling edge.

Structure
REQ-030 A shared package serial_parity_pkg SHALL define the FSM state type and the default DATA_W.
REQ-031 The package SHALL define the frame-bit constants START_BIT=0 and STOP_BIT=1.
REQ-032 The parity accumulator SHALL be one sub-module, parity_acc: a 1-bit register with clear, enable and XOR-in, sharing clk and rst.

Verification
REQ-033 Frame 0xA5, even parity, parity bit 0, stop 1 -> valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
REQ-034 Frame 0x01, even parity, parity bit 0 -> valid pulse, data_out=0x01, parity_err=1.
REQ-035 Frame 0x3C, correct parity, stop bit 0 -> valid pulse, data_out=0x3C, frame_err=1, parity_err=0.
REQ-036 rst pulsed after the 4th data bit, then frame 0x5A -> no valid before reset; one valid after the next frame, with data_out=0x5A.
REQ-037 Frames 0xFF then 0x00 back-to-back with irregular bit_en gaps (1-5 idle cycles) -> two valid pulses, each 1 clock after its stop strobe, with data 0xFF then 0x00.
REQ-038 ODD_PARITY=1, frame 0x07, parity bit 0 -> parity_err=0; the same frame with parity bit 1 -> parity_err=1.
